uart_rx: RTL

- Serial receiver paired with the existing UART transmitter; sits on the board/link input pin.
- Deserialises 8N1 frames (LSB first, 1 start bit, 1 stop bit) and presents bytes on a valid/ready handshake to the downstream link logic.
- Flags framing errors and overruns.
- Same baud/clock parameterisation and `ena` clock-enable gating as the transmitter.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_sync.sv | 25 ++
 rtl/uart_rx.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud-timing helper,
// used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } uart_rx_state;

    // Clocks per bit, integer-truncated.
    function automatic int pulse_width(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous serial line; resets to the
// idle-high level and is never gated by the clock enable.
module uart_rx_sync #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sync_q;

    // Shift chain: oldest sample sits at the MSB.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= {DEPTH{1'b1}};
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of the synchronised line, byte delivery
// on a valid/ready handshake, framing-error pulse and sticky overrun flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 115_200,
    parameter int CLK_FREQ   = 50_000_000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ena,
    input  logic                  rx_signal,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_frame_err,
    output logic                  rx_overrun
);

    localparam int PULSE_WIDTH      = pulse_width(CLK_FREQ, BAUD_RATE);
    localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
    localparam int CNT_W            = $clog2(PULSE_WIDTH) + 1;
    localparam int BIT_W            = $clog2(DATA_WIDTH) + 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_ZERO = BIT_W'(0);

    logic                  rx_s;
    uart_rx_state          state_q,     state_d;
    logic [CNT_W-1:0]      clk_cnt_q,   clk_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q,   bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q,     shift_d;
    logic [DATA_WIDTH-1:0] data_q,      data_d;
    logic                  valid_q,     valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q,   overrun_d;
    logic                  deliver_s;
    logic                  consume_s;
    logic                  cnt_done_s;

    uart_rx_sync #(
        .DEPTH (2)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (rx_signal),
        .q_o     (rx_s)
    );

    assign cnt_done_s = (clk_cnt_q == CNT_ZERO);
    assign consume_s  = valid_q & rx_ready;

    // State and output registers; everything holds when ena is low except the
    // framing-error pulse, which must never stretch across a gated cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            clk_cnt_q   <= CNT_ZERO;
            bit_cnt_q   <= BIT_ZERO;
            shift_q     <= {DATA_WIDTH{1'b0}};
            data_q      <= {DATA_WIDTH{1'b0}};
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (ena) begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end else begin
            frame_err_q <= 1'b0;
        end
    end

    // Next-state: bit timing, deserialisation and the output handshake.
    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        frame_err_d = 1'b0;
        deliver_s   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    clk_cnt_d = CNT_HALF;
                    state_d   = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (!cnt_done_s) begin
                    clk_cnt_d = clk_cnt_q - CNT_ONE;
                end else if (rx_s) begin
                    state_d = IDLE;
                end else begin
                    clk_cnt_d = CNT_FULL;
                    bit_cnt_d = BIT_ZERO;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (!cnt_done_s) begin
                    clk_cnt_d = clk_cnt_q - CNT_ONE;
                end else begin
                    // LSB arrives first, so shifting in at the MSB leaves bit 0 at the bottom.
                    shift_d   = {rx_s, shift_q[DATA_WIDTH-1:1]};
                    clk_cnt_d = CNT_FULL;
                    bit_cnt_d = bit_cnt_q + BIT_ONE;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            STOP: begin
                if (!cnt_done_s) begin
                    clk_cnt_d = clk_cnt_q - CNT_ONE;
                end else if (rx_s) begin
                    deliver_s = 1'b1;
                    state_d   = IDLE;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                // A held-low break must return high before a new start bit counts.
                if (rx_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (deliver_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            if (valid_q && !rx_ready) begin
                overrun_d = 1'b1;
            end else if (consume_s) begin
                overrun_d = 1'b0;
            end else begin
                overrun_d = overrun_q;
            end
        end else if (consume_s) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end else begin
            valid_d   = valid_q;
            overrun_d = overrun_q;
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = frame_err_q;
    assign rx_overrun   = overrun_q;

endmodule
